// File: rtl/pump_duty_ramp.sv
// Per-pump duty slew limiter with emergency stop and minimum-off-time lockout.
// Sits between the filter FSM's duty request and the PWM generator.
module pump_duty_ramp #(
  parameter int unsigned STEP          = 8,
  parameter int unsigned TICK_DIV      = 50_000,
  parameter int unsigned LOCKOUT_TICKS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target_duty,
  input  logic       force_off,
  output logic [7:0] duty_out,
  output logic       at_target,
  output logic       lockout_active
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LW = $clog2(LOCKOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_TICKS);
  localparam logic [8:0]    STEP9     = 9'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      duty_q, duty_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            lockout_q;
  logic            tick_s;
  logic [7:0]      step_duty_s;
  logic [8:0]      duty9_s, tgt9_s, up9_s, dn9_s;

  // Free-running ramp tick divider
  always_comb begin
    tick_s     = 1'b0;
    tick_cnt_d = tick_cnt_q + TW'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_s     = 1'b1;
      tick_cnt_d = '0;
    end else begin
      tick_s     = 1'b0;
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // One clamped step toward the current target; 9-bit math keeps 255/0 from wrapping
  always_comb begin
    duty9_s     = {1'b0, duty_q};
    tgt9_s      = {1'b0, target_duty};
    up9_s       = duty9_s + STEP9;
    dn9_s       = duty9_s - STEP9;
    step_duty_s = duty_q;
    if (duty_q < target_duty) begin
      step_duty_s = (up9_s > tgt9_s) ? target_duty : up9_s[7:0];
    end else if (duty_q > target_duty) begin
      step_duty_s = (duty9_s <= (tgt9_s + STEP9)) ? target_duty : dn9_s[7:0];
    end else begin
      step_duty_s = duty_q;
    end
  end

  // Next-state, duty and lockout counter decode; force_off overrides every state
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    lock_cnt_d = lock_cnt_q;
    if (force_off) begin
      state_d    = ST_LOCKOUT;
      duty_d     = 8'd0;
      lock_cnt_d = LOCK_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = 8'd0;
          if (target_duty != 8'd0) begin
            state_d = ST_RAMP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (tick_s) begin
            duty_d = step_duty_s;
            if ((step_duty_s == target_duty) && (target_duty != 8'd0)) begin
              state_d = ST_HOLD;
            end else if (step_duty_s == 8'd0) begin
              // Zero reached by ramping down must honour the off time;
              // a request withdrawn before any step simply falls back to idle.
              if (duty_q != 8'd0) begin
                state_d    = ST_LOCKOUT;
                lock_cnt_d = LOCK_LOAD;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_RAMP;
            end
          end else begin
            state_d = ST_RAMP;
          end
        end
        ST_HOLD: begin
          if (target_duty != duty_q) begin
            state_d = ST_RAMP;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_LOCKOUT: begin
          duty_d = 8'd0;
          if (tick_s) begin
            if (lock_cnt_q <= LW'(1)) begin
              state_d    = ST_IDLE;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q - LW'(1);
            end
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end
        default: begin
          state_d    = ST_LOCKOUT;
          duty_d     = 8'd0;
          lock_cnt_d = LOCK_LOAD;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      duty_q     <= 8'd0;
      tick_cnt_q <= '0;
      lock_cnt_q <= '0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      tick_cnt_q <= tick_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      lockout_q  <= (state_d == ST_LOCKOUT);
    end
  end

  assign duty_out       = duty_q;
  assign lockout_active = lockout_q;
  assign at_target      = (duty_q == target_duty) && (state_q != ST_LOCKOUT);

endmodule
